// File: rtl/fb_port_arbiter_if.sv
// rtl/fb_port_arbiter_if.sv - requester and RAM-side signal bundle for the frame-buffer port arbiter
interface fb_port_arbiter_if #(
  parameter int c_nb_img_pxls = 15,
  parameter int c_nb_buf      = 12
);
  logic                     disp_rd_en;
  logic [c_nb_img_pxls-1:0] disp_addr;
  logic [c_nb_buf-1:0]      disp_data;
  logic                     disp_valid;

  logic                     cam_we;
  logic [c_nb_img_pxls-1:0] cam_addr;
  logic [c_nb_buf-1:0]      cam_data;
  logic                     cam_full;
  logic                     cam_ovf;
  logic                     ovf_clr;

  logic                     proc_req;
  logic [c_nb_img_pxls-1:0] proc_addr;
  logic                     proc_gnt;
  logic [c_nb_buf-1:0]      proc_data;
  logic                     proc_valid;

  logic [c_nb_img_pxls-1:0] mem_addr;
  logic                     mem_we;
  logic [c_nb_buf-1:0]      mem_wdata;
  logic [c_nb_buf-1:0]      mem_rdata;

  modport slave (
    input  disp_rd_en, disp_addr, cam_we, cam_addr, cam_data, ovf_clr,
           proc_req, proc_addr, mem_rdata,
    output disp_data, disp_valid, cam_full, cam_ovf, proc_gnt, proc_data,
           proc_valid, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output disp_rd_en, disp_addr, cam_we, cam_addr, cam_data, ovf_clr,
           proc_req, proc_addr, mem_rdata,
    input  disp_data, disp_valid, cam_full, cam_ovf, proc_gnt, proc_data,
           proc_valid, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - single-port frame-buffer arbiter: display read, buffered camera writes, aged processing reads
module fb_port_arbiter #(
  parameter int c_nb_img_pxls  = 15,
  parameter int c_nb_buf       = 12,
  parameter int c_wfifo_depth  = 4,
  parameter int c_proc_maxwait = 8
) (
  input logic               clk,
  input logic               rst,
  fb_port_arbiter_if.slave  bus
);
  localparam int c_pw  = $clog2(c_wfifo_depth);
  localparam int c_wcw = (c_proc_maxwait < 1) ? 1 : $clog2(c_proc_maxwait + 1);
  localparam logic [c_pw:0]    c_full_cnt = c_wfifo_depth[c_pw:0];
  localparam logic [c_wcw-1:0] c_max_wait = c_proc_maxwait[c_wcw-1:0];

  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_PROC} tag_t;
  typedef enum logic [1:0] {ACC_IDLE, ACC_DISP, ACC_PROC, ACC_WR} acc_t;

  logic [c_nb_img_pxls-1:0] fifo_addr_q [c_wfifo_depth];
  logic [c_nb_img_pxls-1:0] fifo_addr_d [c_wfifo_depth];
  logic [c_nb_buf-1:0]      fifo_data_q [c_wfifo_depth];
  logic [c_nb_buf-1:0]      fifo_data_d [c_wfifo_depth];
  logic [c_pw-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [c_pw:0]            count_q, count_d;
  logic [c_wcw-1:0]         wait_q, wait_d;
  logic                     ovf_q, ovf_d;
  tag_t                     tag1_q, tag1_d, tag2_q, tag2_d;
  logic [c_nb_buf-1:0]      disp_data_q, disp_data_d, proc_data_q, proc_data_d;
  logic [c_nb_img_pxls-1:0] mem_addr_q, mem_addr_d;
  logic [c_nb_buf-1:0]      mem_wdata_q, mem_wdata_d;

  acc_t acc;
  logic fifo_full, fifo_empty, aged, pop, push;

  // One access per cycle; the aged processing read only jumps the FIFO while
  // the FIFO can still absorb a camera pixel.
  always_comb begin
    fifo_full  = (count_q == c_full_cnt);
    fifo_empty = (count_q == '0);
    aged       = bus.proc_req && (wait_q >= c_max_wait) && !fifo_full;
    acc        = ACC_IDLE;
    if (!rst) begin
      if (bus.disp_rd_en)    acc = ACC_DISP;
      else if (aged)         acc = ACC_PROC;
      else if (!fifo_empty)  acc = ACC_WR;
      else if (bus.proc_req) acc = ACC_PROC;
    end
    pop  = (acc == ACC_WR);
    push = bus.cam_we && (!fifo_full || pop);
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    bus.mem_we  = 1'b0;
    case (acc)
      ACC_DISP: mem_addr_d = bus.disp_addr;
      ACC_PROC: mem_addr_d = bus.proc_addr;
      ACC_WR: begin
        mem_addr_d  = fifo_addr_q[rd_ptr_q];
        mem_wdata_d = fifo_data_q[rd_ptr_q];
        bus.mem_we  = 1'b1;
      end
      default: ;
    endcase
    bus.mem_addr  = mem_addr_d;
    bus.mem_wdata = mem_wdata_d;
    bus.proc_gnt  = (acc == ACC_PROC);
  end

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = bus.cam_addr;
      fifo_data_d[wr_ptr_q] = bus.cam_data;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + {{c_pw{1'b0}}, push} - {{c_pw{1'b0}}, pop};

    ovf_d = ovf_q;
    if (bus.ovf_clr)          ovf_d = 1'b0;
    if (bus.cam_we && !push)  ovf_d = 1'b1;

    wait_d = '0;
    if (bus.proc_req && (acc != ACC_PROC))
      wait_d = (wait_q == c_max_wait) ? wait_q : wait_q + 1'b1;

    // Tag follows the read through the RAM cycle and the output register.
    tag1_d = (acc == ACC_DISP) ? TAG_DISP : (acc == ACC_PROC) ? TAG_PROC : TAG_NONE;
    tag2_d = tag1_q;
    disp_data_d = (tag1_q == TAG_DISP) ? bus.mem_rdata : disp_data_q;
    proc_data_d = (tag1_q == TAG_PROC) ? bus.mem_rdata : proc_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      ovf_q       <= 1'b0;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      disp_data_q <= '0;
      proc_data_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      ovf_q       <= ovf_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      disp_data_q <= disp_data_d;
      proc_data_q <= proc_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = (tag2_q == TAG_DISP);
  assign bus.proc_data  = proc_data_q;
  assign bus.proc_valid = (tag2_q == TAG_PROC);
  assign bus.cam_full   = fifo_full;
  assign bus.cam_ovf    = ovf_q;
endmodule
